// File: rtl/ssm_head_scheduler.sv
// ssm_head_scheduler
// Per-token sequencer for the FP16 SSM core. For every accepted step it walks
// heads 0..H-1: load operands, pulse the core start, wait for core done, store
// h_next/y. A core that never finishes is abandoned after TIMEOUT wait cycles
// and flagged through a sticky error.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   step_valid/step_ready token step handshake (ready only while idle)
//   ld_req/ld_head/ld_ack operand load request, head index, completion
//   core_start/core_head  one-cycle start pulse and head for the SSM core
//   core_done             core completion (only observed while waiting)
//   st_req/st_head/st_ack result store request, head index, completion
//   step_done             one-cycle pulse after the last head is stored
//   busy                  high whenever a step is in progress
//   err_timeout           sticky core-hang flag, cleared on the next accept
//   tok_count             completed-step counter, wraps modulo 2^TW
module ssm_head_scheduler #(
  parameter int H       = 4,
  parameter int HEAD_W  = 2,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_valid,
  output logic              step_ready,
  output logic              ld_req,
  output logic [HEAD_W-1:0] ld_head,
  input  logic              ld_ack,
  output logic              core_start,
  output logic [HEAD_W-1:0] core_head,
  input  logic              core_done,
  output logic              st_req,
  output logic [HEAD_W-1:0] st_head,
  input  logic              st_ack,
  output logic              step_done,
  output logic              busy,
  output logic              err_timeout,
  output logic [TW-1:0]     tok_count
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [HEAD_W-1:0] HEAD_ZERO = HEAD_W'(0);
  localparam logic [HEAD_W-1:0] HEAD_ONE  = HEAD_W'(1);
  localparam logic [HEAD_W-1:0] HEAD_LAST = HEAD_W'(H - 1);
  localparam logic [CW-1:0]     TCNT_ZERO = CW'(0);
  localparam logic [CW-1:0]     TCNT_ONE  = CW'(1);
  localparam logic [CW-1:0]     TCNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [TW-1:0]     TOK_ZERO  = TW'(0);
  localparam logic [TW-1:0]     TOK_ONE   = TW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [HEAD_W-1:0] head_r, head_s;
  logic [CW-1:0]     tcnt_r, tcnt_s;
  logic              err_r, err_s;
  logic [TW-1:0]     tok_r, tok_s;

  logic step_ready_r, ld_req_r, core_start_r, st_req_r, step_done_r, busy_r;

  // Next-state, head, timeout counter, error and token counter updates.
  always_comb begin
    state_s = state_r;
    head_s  = head_r;
    tcnt_s  = tcnt_r;
    err_s   = err_r;
    tok_s   = tok_r;
    case (state_r)
      IDLE: begin
        if (step_valid) begin
          head_s  = HEAD_ZERO;
          err_s   = 1'b0;
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (ld_ack) begin
          state_s = START;
        end else begin
          state_s = LOAD;
        end
      end
      START: begin
        // core_done is deliberately not looked at here
        tcnt_s  = TCNT_ZERO;
        state_s = WAIT;
      end
      WAIT: begin
        tcnt_s = tcnt_r + TCNT_ONE;
        // done has priority over an expiring timeout in the same cycle
        if (core_done) begin
          state_s = STORE;
        end else if (tcnt_r == TCNT_LAST) begin
          err_s   = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      STORE: begin
        if (st_ack) begin
          if (head_r == HEAD_LAST) begin
            state_s = DONE;
          end else begin
            head_s  = head_r + HEAD_ONE;
            state_s = LOAD;
          end
        end else begin
          state_s = STORE;
        end
      end
      DONE: begin
        tok_s   = tok_r + TOK_ONE;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State registers plus output flags registered from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      head_r       <= HEAD_ZERO;
      tcnt_r       <= TCNT_ZERO;
      err_r        <= 1'b0;
      tok_r        <= TOK_ZERO;
      step_ready_r <= 1'b1;
      ld_req_r     <= 1'b0;
      core_start_r <= 1'b0;
      st_req_r     <= 1'b0;
      step_done_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      head_r       <= head_s;
      tcnt_r       <= tcnt_s;
      err_r        <= err_s;
      tok_r        <= tok_s;
      step_ready_r <= (state_s == IDLE);
      ld_req_r     <= (state_s == LOAD);
      core_start_r <= (state_s == START);
      st_req_r     <= (state_s == STORE);
      step_done_r  <= (state_s == DONE);
      busy_r       <= (state_s != IDLE);
    end
  end

  assign step_ready  = step_ready_r;
  assign ld_req      = ld_req_r;
  assign ld_head     = head_r;
  assign core_start  = core_start_r;
  assign core_head   = head_r;
  assign st_req      = st_req_r;
  assign st_head     = head_r;
  assign step_done   = step_done_r;
  assign busy        = busy_r;
  assign err_timeout = err_r;
  assign tok_count   = tok_r;

endmodule

// File: doc/ssm_head_scheduler.md
Name: ssm_head_scheduler

Overview:
- Per-token sequencer for the FP16 SSM core (dBx → dA·h + dBx → h·C → +D·x).
- Walks heads 0..H-1 one at a time. For each head it fetches state/operands, pulses the core's start, waits for core done, then writes back h_next and y.
- Sits between the token/layer controller (step handshake) and the operand memory plus the SSM core.
- Raises a sticky timeout error if the core hangs.

Parameters:
- H, 4, number of heads sequenced per step.
- HEAD_W, 2, width of the head index; must satisfy 2^HEAD_W >= H.
- TIMEOUT, 1024, max cycles allowed in WAIT before the core is declared hung (>= 2).
- TW, 16, width of the completed-step counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- step_valid  in  1  request to process one token step.
- step_ready  out  1  high only in IDLE.
- ld_req  out  1  load request for head ld_head (h_prev, x, dt, dA slices).
- ld_head  out  HEAD_W  head index for the load.
- ld_ack  in  1  load complete; sampled only while ld_req=1.
- core_start  out  1  one-cycle start pulse to the SSM core.
- core_head  out  HEAD_W  head the core is processing.
- core_done  in  1  core finished; sampled only in WAIT.
- st_req  out  1  store request for head st_head (h_next, y).
- st_head  out  HEAD_W  head index for the store.
- st_ack  in  1  store complete; sampled only while st_req=1.
- step_done  out  1  one-cycle pulse when all H heads are stored.
- busy  out  1  high in any state except IDLE.
- err_timeout  out  1  sticky; set on timeout, cleared on the next accepted step.
- tok_count  out  TW  count of completed steps; wraps modulo 2^TW.

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-step):
  - state=IDLE, head=0, timeout counter=0.
  - All request/pulse outputs=0, busy=0, err_timeout=0, tok_count=0.
  - step_ready=1 from the first cycle after reset.
  - An in-flight core operation is abandoned; any later core_done is ignored.
- States: IDLE, LOAD, START, WAIT, STORE, DONE.
- IDLE:
  - step_ready=1.
  - Accepting step_valid & step_ready: head<=0, err_timeout<=0, next=LOAD.
- LOAD:
  - ld_req=1, ld_head=head.
  - ld_ack=1 in the same cycle → START.
  - ld_req stays high until ack; it drops the cycle after ack.
- START:
  - core_start=1 for exactly this one cycle, core_head=head.
  - next=WAIT and the timeout counter clears.
  - core_done in this cycle is ignored.
- WAIT:
  - core_head held stable; the counter increments each cycle.
  - core_done=1 → STORE.
  - Otherwise, if the counter reaches TIMEOUT-1: err_timeout<=1, next=IDLE. No store, no step_done, tok_count unchanged.
  - core_done and timeout in the same cycle: done wins.
- STORE:
  - st_req=1, st_head=head.
  - On st_ack: if head==H-1 → DONE; else head<=head+1, next=LOAD.
- DONE:
  - step_done=1 for one cycle, tok_count<=tok_count+1 (wraps), next=IDLE.
- ld_head, core_head and st_head all equal the internal head register, which holds its value in IDLE.
- ld_ack/st_ack asserted while the matching req=0 are ignored. Persistent step_valid in DONE is not accepted until IDLE.
- Latency with acks returned in the same cycle as req and core_done k cycles after core_start (k>=1):
  - Per head = 1 (LOAD) + 1 (START) + k (WAIT) + 1 (STORE) = k+3 cycles.
  - step_done is asserted H·(k+3)+1 cycles after the accept cycle.
- Throughput: one step in flight. A new step can be accepted in the cycle after DONE.

Test Plan:
- Basic step: H=4, acks tied to 1, core_done 3 cycles after each core_start.
  - core_start pulses exactly 4 times, with core_head 0,1,2,3.
  - step_done is one cycle, 25 cycles after accept.
  - tok_count=1, err_timeout=0.
- Ack stall: ld_ack delayed 5 cycles on head 2, st_ack delayed 2 cycles on head 0.
  - ld_req/st_req stay high through the stall with a stable head index.
  - Total latency grows by exactly 7 cycles; no extra core_start.
- Timeout: TIMEOUT=16, core_done never asserted on head 1.
  - err_timeout=1 after 16 WAIT cycles; state returns to IDLE with step_ready=1.
  - No st_req for head 1, no step_done, tok_count unchanged.
  - Next accepted step clears err_timeout.
- Done/timeout race: core_done asserted in the final WAIT cycle (count=TIMEOUT-1).
  - Proceeds to STORE; err_timeout stays 0.
- Reset mid-step: rst=1 for one cycle during WAIT of head 2.
  - Next cycle shows IDLE, all outputs 0 except step_ready=1, tok_count=0.
  - A stray core_done after reset causes no transition.
- Back-to-back steps with step_valid held high and TW=2: run 5 steps.
  - Each new accept occurs exactly 1 cycle after its step_done.
  - tok_count reads 1,2,3,0,1.
